// File: rtl/multiplicador_algoritmico_if.sv
// multiplicador_algoritmico_if: Start/Done handshake and operand/result bundle for the sequential multiplier.
interface multiplicador_algoritmico_if #(parameter int tamanyo = 32);
  logic                   Start;
  logic [tamanyo-1:0]     A;
  logic [tamanyo-1:0]     B;
  logic [2*tamanyo-1:0]   Producto;
  logic                   Busy;
  logic                   Done;
  modport master (output Start, A, B, input Producto, Busy, Done);
  modport slave (input Start, A, B, output Producto, Busy, Done);
endinterface

// File: rtl/multiplicador_algoritmico.sv
// multiplicador_algoritmico: signed shift-and-add multiplier, one multiplier bit per clock.
// Define MULT_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module multiplicador_algoritmico #(parameter int tamanyo = 32) (
  input logic CLK,
  input logic RSTa,
  multiplicador_algoritmico_if.slave bus
);
  localparam int cw = $clog2(tamanyo) + 1;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0] estado;
  logic sa, sb, done, busy, fin;
  logic [2*tamanyo-1:0] mc, p, producto;
  logic [tamanyo-1:0] q;
  logic [cw-1:0] cont;
`ifdef MULT_EARLY_EXIT_EN
  assign fin = cont == cw'(1) || ~|q[tamanyo-1:1];
`else
  assign fin = cont == cw'(1);
`endif
  assign bus.Producto = producto;
  assign bus.Busy = busy;
  assign bus.Done = done;
  // Magnitudes are multiplied unsigned; the sign is restored in FIX, so -2^(n-1) needs no special case.
  always_ff @(posedge CLK or negedge RSTa)
    if (!RSTa) begin
      estado <= IDLE;
      sa <= 1'b0;
      sb <= 1'b0;
      mc <= '0;
      p <= '0;
      q <= '0;
      cont <= '0;
      producto <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      if (estado == IDLE) begin
        if (bus.Start) begin
          sa <= bus.A[tamanyo-1];
          sb <= bus.B[tamanyo-1];
          mc <= {{tamanyo{1'b0}}, bus.A[tamanyo-1] ? -bus.A : bus.A};
          q <= bus.B[tamanyo-1] ? -bus.B : bus.B;
          p <= '0;
          cont <= cw'(tamanyo);
          busy <= 1'b1;
          estado <= CALC;
        end
      end else if (estado == CALC) begin
        if (q[0]) p <= p + mc;
        mc <= mc << 1;
        q <= q >> 1;
        cont <= cont - cw'(1);
        if (fin) estado <= FIX;
      end else if (estado == FIX) begin
        producto <= (sa ^ sb) ? -p : p;
        done <= 1'b1;
        busy <= 1'b0;
        estado <= IDLE;
      end else begin
        estado <= IDLE;
      end
    end
endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// tb_multiplicador_algoritmico: 8-bit and 32-bit multipliers checked every cycle against a countdown/arithmetic model.
module tb_multiplicador_algoritmico;
`ifdef MULT_EARLY_EXIT_EN
  localparam int L76 = 4, L31 = 2;
`else
  localparam int L76 = 9, L31 = 33;
`endif
  logic CLK = 1'b0, RSTa = 1'b0, on = 1'b0;
  int tests = 0, fails = 0;
  multiplicador_algoritmico_if #(.tamanyo(8)) i8();
  multiplicador_algoritmico_if #(.tamanyo(32)) i32();
  multiplicador_algoritmico #(.tamanyo(8)) dut8(.CLK(CLK), .RSTa(RSTa), .bus(i8.slave));
  multiplicador_algoritmico #(.tamanyo(32)) dut32(.CLK(CLK), .RSTa(RSTa), .bus(i32.slave));
  always #5 CLK = ~CLK;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] mref(int k, logic [31:0] a, logic [31:0] b);
    longint x, y, r;
    x = k != 0 ? longint'($signed(a)) : longint'($signed(a[7:0]));
    y = k != 0 ? longint'($signed(b)) : longint'($signed(b[7:0]));
    r = x * y;
    return 64'(r) & (k != 0 ? 64'hFFFFFFFFFFFFFFFF : 64'hFFFF);
  endfunction

  function automatic int mlat(int k, logic [31:0] b);
    int n, h;
    longint y;
    n = k != 0 ? 32 : 8;
    h = n - 1;
`ifdef MULT_EARLY_EXIT_EN
    y = k != 0 ? longint'($signed(b)) : longint'($signed(b[7:0]));
    if (y < 0) y = -y;
    h = 0;
    for (int i = 0; i < n; i++) if (y[i]) h = i;
`else
    y = 0;
`endif
    return 2 + h + int'(y[63]);
  endfunction

  logic st [2];
  logic [31:0] ia [2], ib [2];
  logic [63:0] mp [2], mq [2], op [2];
  logic mb [2], md [2], ob [2], od [2];
  int ml [2];
  assign st[0] = i8.Start;
  assign st[1] = i32.Start;
  assign ia[0] = {24'b0, i8.A};
  assign ia[1] = i32.A;
  assign ib[0] = {24'b0, i8.B};
  assign ib[1] = i32.B;
  assign op[0] = {48'b0, i8.Producto};
  assign op[1] = i32.Producto;
  assign ob[0] = i8.Busy;
  assign ob[1] = i32.Busy;
  assign od[0] = i8.Done;
  assign od[1] = i32.Done;

  // Model: an accepted Start arms a countdown of the expected latency; Done fires when it expires.
  always @(posedge CLK or negedge RSTa)
    for (int k = 0; k < 2; k++)
      if (!RSTa) begin
        ml[k] <= 0;
        mb[k] <= 1'b0;
        md[k] <= 1'b0;
        mp[k] <= '0;
        mq[k] <= '0;
      end else if (ml[k] != 0) begin
        ml[k] <= ml[k] - 1;
        md[k] <= ml[k] == 1;
        if (ml[k] == 1) begin
          mb[k] <= 1'b0;
          mp[k] <= mq[k];
        end
      end else begin
        md[k] <= 1'b0;
        if (st[k]) begin
          mq[k] <= mref(k, ia[k], ib[k]);
          ml[k] <= mlat(k, ib[k]);
          mb[k] <= 1'b1;
        end
      end

  always @(negedge CLK)
    if (RSTa && on)
      for (int k = 0; k < 2; k++) begin
        check(k != 0 ? "busy32" : "busy8", 64'(ob[k]), 64'(mb[k]));
        check(k != 0 ? "done32" : "done8", 64'(od[k]), 64'(md[k]));
        check(k != 0 ? "prod32" : "prod8", op[k], mp[k]);
      end

  task automatic wait_done(int k, int n0, output int n);
    n = n0;
    while (!(k != 0 ? i32.Done : i8.Done) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic run(int k, logic [31:0] a, logic [31:0] b, output int n, output logic [63:0] pr);
    if (k != 0) begin
      i32.Start = 1'b1; i32.A = a; i32.B = b;
    end else begin
      i8.Start = 1'b1; i8.A = a[7:0]; i8.B = b[7:0];
    end
    @(negedge CLK);
    i8.Start = 1'b0;
    i32.Start = 1'b0;
    wait_done(k, 0, n);
    pr = k != 0 ? i32.Producto : {48'b0, i8.Producto};
  endtask

  initial begin
    int n, cnt;
    logic [63:0] pr;
    i8.Start = 1'b0; i8.A = '0; i8.B = '0;
    i32.Start = 1'b0; i32.A = '0; i32.B = '0;
    repeat (2) @(negedge CLK);
    check("rst_prod8", op[0], 64'h0);
    check("rst_busy8", 64'(i8.Busy), 64'h0);
    check("rst_done8", 64'(i8.Done), 64'h0);
    check("model_pin_neg", mref(0, 32'hF9, 32'h6), 64'hFFD6);
    check("model_pin_min", mref(1, 32'h80000000, 32'h80000000), 64'h4000000000000000);
    RSTa = 1'b1;
    on = 1'b1;
    @(negedge CLK);
    run(0, 7, 6, n, pr);
    check("t1_prod", pr, 64'd42);
    check("t1_lat", 64'(n), 64'(L76));
    @(negedge CLK);
    check("t1_done_once", 64'(i8.Done), 64'h0);
    run(0, 32'hF9, 6, n, pr);
    check("neg_pos", pr, 64'hFFD6);
    run(0, 32'hF9, 32'hFA, n, pr);
    check("neg_neg", pr, 64'd42);
    run(0, 0, 32'hFB, n, pr);
    check("zero", pr, 64'h0);
    run(0, 32'h80, 32'h80, n, pr);
    check("min_min", pr, 64'h4000);
    run(0, 32'h80, 32'h7F, n, pr);
    check("min_max", pr, 64'hC080);
    run(0, 32'h7F, 32'h7F, n, pr);
    check("max_max", pr, 64'h3F01);
    @(negedge CLK);
    i8.Start = 1'b1; i8.A = 5; i8.B = 5;
    @(negedge CLK);
    i8.Start = 1'b0;
    repeat (3) @(negedge CLK);
    i8.Start = 1'b1; i8.A = 3; i8.B = 3;
    @(negedge CLK);
    i8.Start = 1'b0;
    wait_done(0, 4, n);
    check("busy_ignore_prod", op[0], 64'd25);
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      cnt += int'(i8.Done);
    end
    check("busy_ignore_no_second_done", 64'(cnt), 64'h0);
    i8.Start = 1'b1; i8.A = 5; i8.B = 5;
    @(negedge CLK);
    i8.Start = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RSTa = 1'b0;
    #1;
    check("async_rst_prod", op[0], 64'h0);
    check("async_rst_done", 64'(i8.Done), 64'h0);
    check("async_rst_busy", 64'(i8.Busy), 64'h0);
    @(negedge CLK);
    RSTa = 1'b1;
    run(0, 2, 9, n, pr);
    check("after_rst", pr, 64'd18);
    @(negedge CLK);
    run(1, 3, 1, n, pr);
    check("w32_small", pr, 64'd3);
    check("w32_small_lat", 64'(n), 64'(L31));
    run(1, 1, 32'h80000000, n, pr);
    check("w32_minb", pr, 64'hFFFFFFFF80000000);
    check("w32_minb_lat", 64'(n), 64'd33);
    run(1, 32'h80000000, 32'h80000000, n, pr);
    check("w32_min_min", pr, 64'h4000000000000000);
    run(1, 32'hFFFFFFFD, 32'd100000, n, pr);
    check("w32_neg", pr, 64'hFFFFFFFFFFFB6C20);
    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
